// File: rtl/nibble_arb_pkg.sv
// Shared types and helpers for the nibble-enable register arbiter.
// Holds the FSM state encoding, the half count and the round-robin pointer step.
package nibble_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } arb_state_e;

  localparam int NIB_HALVES = 2;

  // Pointer moves to the slot after the last winner, wrapping at num_req.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num_req);
    return (idx + 32'd1 >= num_req) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/nibble_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Returns the winner both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [PTR_W-1:0]   win_idx_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] cand;
  logic             found;

  // NOTE: every signal written here gets a default before the loop, so no latch is inferred.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_oh_o[cand]  = 1'b1;
        win_idx_o       = cand;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/nibble_reg_arbiter.sv
// Round-robin arbiter sharing one register among NUM_REQ writers with per-nibble enables.
// One write per IDLE -> GRANT -> COMMIT pass; clr_i overrides any coincident write.
module nibble_reg_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int                NUM_REQ   = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*DATA_W-1:0]      wdata_i,
  input  logic [NUM_REQ*NIB_HALVES-1:0]  be_i,
  input  logic                           clr_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [DATA_W/2-1:0]            lo_q,
  output logic [DATA_W/2-1:0]            hi_q,
  output logic                           lo_upd_o,
  output logic                           hi_upd_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               wr_cnt_o
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PTR_W  = $clog2(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [PTR_W-1:0]          win_q, win_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [NIB_HALVES-1:0]     upd_q, upd_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0]        pick_oh;
  logic [PTR_W-1:0]          pick_idx;
  logic                      pick_valid;

  logic [DATA_W-1:0]         wdata_arr [NUM_REQ];
  logic [NIB_HALVES-1:0]     be_arr    [NUM_REQ];
  logic [DATA_W-1:0]         win_data;
  logic [NIB_HALVES-1:0]     win_be;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wdata_arr[g] = wdata_i[g*DATA_W +: DATA_W];
    assign be_arr[g]    = be_i[g*NIB_HALVES +: NIB_HALVES];
  end

  assign win_data = wdata_arr[win_q];
  assign win_be   = be_arr[win_q];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    upd_d   = '0;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          gnt_d   = pick_oh;
          state_d = GRANT;
        end
      end
      GRANT: begin
        for (int h = 0; h < NIB_HALVES; h++) begin
          if (win_be[h]) data_d[h*HALF_W +: HALF_W] = win_data[h*HALF_W +: HALF_W];
        end
        upd_d = clr_i ? '0 : win_be;
        ptr_d = PTR_W'(next_ptr(32'(win_q), NUM_REQ));
        // The grant is consumed even when masked by clr_i or with no nibble enabled.
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_i) data_d = RESET_VAL;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      data_q  <= RESET_VAL;
      upd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign lo_q     = data_q[HALF_W-1:0];
  assign hi_q     = data_q[DATA_W-1:HALF_W];
  assign lo_upd_o = upd_q[0];
  assign hi_upd_o = upd_q[1];
  assign busy_o   = (state_q != IDLE);
  assign wr_cnt_o = cnt_q;

endmodule

// File: tb/tb_nibble_reg_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic scored against a
// transaction-level model (grant queue and update-pulse queue).
module tb_nibble_reg_arbiter;

  localparam int         N       = 4;
  localparam int         DW      = 8;
  localparam int         CNT_W   = 6;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0] RST_V   = 8'h00;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req   = '0;
  logic [N*DW-1:0]  wdata = '0;
  logic [N*2-1:0]   be    = '0;
  logic             clr   = 1'b0;
  logic [N-1:0]     gnt_o;
  logic [3:0]       lo_q, hi_q;
  logic             lo_upd_o, hi_upd_o, busy_o;
  logic [CNT_W-1:0] wr_cnt_o;

  nibble_reg_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .RESET_VAL (RST_V),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .wdata_i  (wdata),
    .be_i     (be),
    .clr_i    (clr),
    .gnt_o    (gnt_o),
    .lo_q     (lo_q),
    .hi_q     (hi_q),
    .lo_upd_o (lo_upd_o),
    .hi_upd_o (hi_upd_o),
    .busy_o   (busy_o),
    .wr_cnt_o (wr_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [N-1:0] persist      = '0;
  logic [N-1:0] granted_prev = '0;

  int         exp_gnt[$];
  logic [1:0] exp_upd[$];
  int         obs_idx[$];
  int         obs_cyc[$];

  logic [7:0] m_reg   = RST_V;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  int         m_phase = 0;
  int         m_win   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: one write per three cycles, round-robin from the slot after the last winner.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   = RST_V;
      m_ptr   = 0;
      m_cnt   = 0;
      m_phase = 0;
      m_win   = 0;
      exp_gnt.delete();
      exp_upd.delete();
    end else begin
      logic [7:0] nxt, d, mask;
      logic [1:0] b;
      bit         found;
      nxt = m_reg;
      if (m_phase == 1) begin
        d    = wdata[m_win*8 +: 8];
        b    = be[m_win*2 +: 2];
        mask = {{4{b[1]}}, {4{b[0]}}};
        nxt  = (m_reg & ~mask) | (d & mask);
        exp_upd.push_back(clr ? 2'b00 : b);
        m_ptr = (m_win + 1) % N;
        if (m_cnt < CNT_MAX) m_cnt++;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else begin
        assert (!$isunknown(req)) else $error("req_i unknown while idle");
        if (req != '0) begin
          found = 1'b0;
          for (int j = 0; j < N; j++) begin
            if (!found && req[(m_ptr + j) % N]) begin
              found = 1'b1;
              m_win = (m_ptr + j) % N;
            end
          end
          exp_gnt.push_back(m_win);
          m_phase = 1;
        end
      end
      if (clr) nxt = RST_V;
      m_reg = nxt;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_gnt.size() != 0) check("gnt", 32'(gnt_o), 32'(1 << exp_gnt.pop_front()));
      else                     check("gnt_idle", 32'(gnt_o), 32'd0);
      if (exp_upd.size() != 0) check("upd", 32'({hi_upd_o, lo_upd_o}), 32'(exp_upd.pop_front()));
      else                     check("upd_idle", 32'({hi_upd_o, lo_upd_o}), 32'd0);
      check("reg", 32'({hi_q, lo_q}), 32'(m_reg));
      check("wr_cnt", 32'(wr_cnt_o), 32'(m_cnt));
      check("busy", 32'(busy_o), 32'(m_phase != 0));
      for (int k = 0; k < N; k++) begin
        if (gnt_o[k]) begin
          obs_idx.push_back(k);
          obs_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic raise(input int k, input logic [7:0] d, input logic [1:0] b);
    req[k]        = 1'b1;
    wdata[k*8 +: 8] = d;
    be[k*2 +: 2]  = b;
  endtask

  // Advance one cycle; grantees drop req (data held through GRANT), persistent ones re-raise.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (granted_prev[k]) begin
        granted_prev[k] = 1'b0;
        if (persist[k]) raise(k, 8'($urandom), 2'($urandom));
      end else if (gnt_o[k]) begin
        req[k]          = 1'b0;
        granted_prev[k] = 1'b1;
      end
    end
  endtask

  task automatic wait_gnt(input int k);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      step();
      if (gnt_o[k]) seen = 1'b1;
    end
    if (!seen) fail_now($sformatf("wait_gnt_timeout_req%0d", k));
  endtask

  task automatic do_write(input int k, input logic [7:0] d, input logic [1:0] b);
    raise(k, d, b);
    wait_gnt(k);
    step();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req          = '0;
    clr          = 1'b0;
    persist      = '0;
    granted_prev = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lo", 32'(lo_q), 32'h0);
    check("rst_hi", 32'(hi_q), 32'h0);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_cnt", 32'(wr_cnt_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_upd", 32'({hi_upd_o, lo_upd_o}), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    do_reset();

    // Single write: req1 with A5 on both halves, exact latency.
    raise(1, 8'hA5, 2'b11);
    step();
    check("single_gnt", 32'(gnt_o), 32'b0010);
    step();
    check("single_lo", 32'(lo_q), 32'h5);
    check("single_hi", 32'(hi_q), 32'hA);
    check("single_upd", 32'({hi_upd_o, lo_upd_o}), 32'b11);
    check("single_cnt", 32'(wr_cnt_o), 32'd1);

    // Partial write: high nibble only.
    do_write(0, 8'h3C, 2'b11);
    check("partial_pre", 32'({hi_q, lo_q}), 32'h3C);
    do_write(0, 8'hFF, 2'b10);
    check("partial_reg", 32'({hi_q, lo_q}), 32'hFC);
    check("partial_upd", 32'({hi_upd_o, lo_upd_o}), 32'b10);

    // Fairness from a fresh pointer: all four requesters persistent.
    do_reset();
    obs_idx.delete();
    obs_cyc.delete();
    persist = '1;
    for (int k = 0; k < N; k++) raise(k, 8'($urandom), 2'($urandom));
    for (int n = 0; n < 40 && obs_idx.size() < 5; n++) step();
    persist = '0;
    req     = '0;
    repeat (3) step();
    if (obs_idx.size() < 5) fail_now("fair_too_few_grants");
    for (int i = 0; i < 5 && i < obs_idx.size(); i++) begin
      check($sformatf("fair_order%0d", i), 32'(obs_idx[i]), 32'(i % N));
      if (i > 0) check($sformatf("fair_gap%0d", i), 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd3);
    end

    // Clear colliding with a full write: clear wins, grant still counted.
    do_write(1, 8'h5A, 2'b11);
    check("pre_clr_reg", 32'({hi_q, lo_q}), 32'h5A);
    check("pre_clr_cnt", 32'(wr_cnt_o), 32'd6);
    raise(2, 8'h77, 2'b11);
    wait_gnt(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_reg", 32'({hi_q, lo_q}), 32'(RST_V));
    check("clr_upd", 32'({hi_upd_o, lo_upd_o}), 32'b00);
    check("clr_cnt", 32'(wr_cnt_o), 32'd7);

    // Reset during GRANT aborts the write; pointer restarts at 0.
    repeat (2) step();
    raise(0, 8'hE7, 2'b11);
    wait_gnt(0);
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt_o), 32'h0);
    check("midrst_reg", 32'({hi_q, lo_q}), 32'(RST_V));
    check("midrst_cnt", 32'(wr_cnt_o), 32'h0);
    req          = '0;
    granted_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    raise(1, 8'h96, 2'b01);
    raise(3, 8'h69, 2'b10);
    rst_n = 1'b1;
    for (int n = 0; n < 10 && gnt_o == '0; n++) step();
    check("midrst_first_gnt", 32'(gnt_o), 32'b0010);

    // Random traffic: raises, withdrawals and clears; counter saturates along the way.
    repeat (2500) begin
      step();
      clr = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++) begin
        if (!gnt_o[k]) begin
          if (req[k]) begin
            if ($urandom_range(0, 19) == 0) req[k] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            raise(k, 8'($urandom), 2'($urandom));
          end
        end
      end
    end
    req = '0;
    clr = 1'b0;
    repeat (6) step();
    check("final_cnt_sat", 32'(wr_cnt_o), 32'(CNT_MAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
